vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing for the stacker game: sync pulses, the `bright` visible-area flag, and the `hCount`/`vCount` raster position that the block controller's pixel-colour logic consumes. It also produces a once-per-N-frames `game_tick` enable. The block controller's sprite/stack state machine advances on that enable rather than on a divided clock, so the whole design stays on a single clock. It sits directly upstream of the block controller and drives the VGA connector pins.

---
 rtl/vga_timing_gen_pkg.sv | 23 ++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_timing_gen_mod_counter.sv | 27 ++
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants for the stacker game (640x480 @ 60 Hz).
// The block controller imports these rather than hard-coding raster positions.
package vga_pkg;

    localparam int COORD_W     = 10;   // hCount / vCount width

    localparam int CLK_DIV     = 4;    // 100 MHz system clock -> 25 MHz pixel rate
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 514;
    localparam int TICK_FRAMES = 6;    // 60 Hz / 6 = 10 Hz game tick

    // Register width for a modulo-n counter; a modulo-1 counter still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers
// (block controller pixel logic and the VGA connector pins).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic               pix_en;
    logic [COORD_W-1:0] hCount;
    logic [COORD_W-1:0] vCount;
    logic               hSync;
    logic               vSync;
    logic               bright;
    logic               frame_tick;
    logic               game_tick;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, game_tick
    );

endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Generic modulo-N counter with enable and a terminal-count decode.
// tc is combinational on the count register so it lines up with the
// edge on which the counter wraps.
module mod_counter
    import vga_pkg::*;
#(
    parameter int N = 4,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(N - 1));

    // Count 0..N-1 while enabled, wrapping back to 0 after the terminal value.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, h/v counters, sync and visible
// flags, per-frame tick and a slower game tick, all on the single system clock.
module vga_timing_gen #(
    parameter int CLK_DIV     = vga_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_pkg::V_VIS_END,
    parameter int TICK_FRAMES = vga_pkg::TICK_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    import vga_pkg::*;

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int FRM_W = cnt_width(TICK_FRAMES);

    localparam logic [COORD_W-1:0] H_SYNC_C  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_C  = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_VIS_S_C = COORD_W'(H_VIS_START);
    localparam logic [COORD_W-1:0] H_VIS_E_C = COORD_W'(H_VIS_END);
    localparam logic [COORD_W-1:0] V_VIS_S_C = COORD_W'(V_VIS_START);
    localparam logic [COORD_W-1:0] V_VIS_E_C = COORD_W'(V_VIS_END);

    // Only the terminal decodes of the pixel and frame dividers matter here.
    logic [DIV_W-1:0]   div_cnt_unused;
    logic [FRM_W-1:0]   frm_cnt_unused;
    logic               div_tc, h_tc, v_tc, frm_tc;
    logic               pix_en, line_wrap, frame_wrap;
    logic [COORD_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;

    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk (clk), .rst (rst), .en (1'b1),
        .cnt (div_cnt_unused), .tc (div_tc)
    );

    mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk (clk), .rst (rst), .en (pix_en),
        .cnt (h_cnt), .tc (h_tc)
    );

    mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk (clk), .rst (rst), .en (line_wrap),
        .cnt (v_cnt), .tc (v_tc)
    );

    mod_counter #(.N(TICK_FRAMES), .W(FRM_W)) u_frm (
        .clk (clk), .rst (rst), .en (frame_wrap),
        .cnt (frm_cnt_unused), .tc (frm_tc)
    );

    assign pix_en     = div_tc;
    assign line_wrap  = pix_en & h_tc;
    assign frame_wrap = line_wrap & v_tc;

    // Position the counters will hold after this edge; decoding flags from it
    // keeps the registered flags aligned with the counts they describe.
    assign h_nxt = !pix_en   ? h_cnt : (h_tc ? '0 : h_cnt + COORD_W'(1));
    assign v_nxt = !line_wrap ? v_cnt : (v_tc ? '0 : v_cnt + COORD_W'(1));

    assign vga.pix_en = pix_en;
    assign vga.hCount = h_cnt;
    assign vga.vCount = v_cnt;

    // Registered sync/visible flags and frame/game tick pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.hSync      <= 1'b0;
            vga.vSync      <= 1'b0;
            vga.bright     <= 1'b0;
            vga.frame_tick <= 1'b0;
            vga.game_tick  <= 1'b0;
        end else begin
            vga.hSync      <= (h_nxt >= H_SYNC_C);
            vga.vSync      <= (v_nxt >= V_SYNC_C);
            vga.bright     <= (h_nxt >= H_VIS_S_C) && (h_nxt <= H_VIS_E_C) &&
                              (v_nxt >= V_VIS_S_C) && (v_nxt <= V_VIS_E_C);
            vga.frame_tick <= frame_wrap;
            vga.game_tick  <= frame_wrap & frm_tc;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down raster (fast frames), a TICK_FRAMES=1
// variant, and the default 640x480 instance, all checked every cycle against a
// position-from-elapsed-time model, plus hand-computed literal checkpoints.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ft;
        logic       gt;
    } vout_t;

    // Small raster: 20x10 positions, 4 clk per pixel -> 80 clk lines, 800 clk frames.
    localparam int FR = 800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k_m = 0;          // clk edges since the last reset edge
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_s ();
    vga_timing_gen_if if_1 ();
    vga_timing_gen_if if_d ();

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(16),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8), .TICK_FRAMES(6)
    ) dut_s (.clk(clk), .rst(rst), .vga(if_s));

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(16),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8), .TICK_FRAMES(1)
    ) dut_1 (.clk(clk), .rst(rst), .vga(if_1));

    vga_timing_gen dut_d (.clk(clk), .rst(rst), .vga(if_d));

    // Expected outputs after kk edges out of reset, from elapsed pixels/lines/frames.
    function automatic vout_t model(input int cd, input int ht, input int hsy,
                                    input int hvs, input int hve, input int vt,
                                    input int vsy, input int vvs, input int vve,
                                    input int tf, input int kk);
        int p, h, l, v, f;
        vout_t o;
        p = kk / cd;
        h = p % ht;
        l = p / ht;
        v = l % vt;
        f = l / vt;
        o.pix_en = ((kk % cd) == cd - 1);
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = (h >= hsy);
        o.vs = (v >= vsy);
        o.br = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
        o.ft = ((kk % cd) == 0) && (h == 0) && (v == 0) && (f > 0);
        o.gt = o.ft && ((f % tf) == 0);
        return o;
    endfunction

    task automatic chk_vec(input string nm, input vout_t a, input vout_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h exp=%h", nm, k_m, a, e);
        end
    endtask

    task automatic chk(input string nm, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, a, e);
        end
    endtask

    always @(posedge clk) k_m <= rst ? 0 : k_m + 1;

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk_vec("small", {if_s.pix_en, if_s.hCount, if_s.vCount, if_s.hSync,
                              if_s.vSync, if_s.bright, if_s.frame_tick, if_s.game_tick},
                    model(4, 20, 3, 5, 16, 10, 2, 3, 8, 6, k_m));
            chk_vec("tick1", {if_1.pix_en, if_1.hCount, if_1.vCount, if_1.hSync,
                              if_1.vSync, if_1.bright, if_1.frame_tick, if_1.game_tick},
                    model(4, 20, 3, 5, 16, 10, 2, 3, 8, 1, k_m));
            chk_vec("vga640", {if_d.pix_en, if_d.hCount, if_d.vCount, if_d.hSync,
                               if_d.vSync, if_d.bright, if_d.frame_tick, if_d.game_tick},
                    model(4, 800, 96, 144, 783, 525, 2, 35, 514, 6, k_m));
        end
    end

    initial begin
        int first_pe, h_at4, n_pe, n_br, n_hs, fb_h, fb_v, lb_h, lb_v;
        int h79, v79, pe79, h80, v80, h799, v799, pe799, h800, v800, ft800, vs800, br800;
        int n_gt1, n_hs_d, n_br_d, d_h, d_v, found, ft_k, gt_k;
        int ft_q[$];
        int gt_q[$];

        first_pe = -1; h_at4 = -1; n_pe = 0; n_br = 0; n_hs = 0;
        fb_h = -1; fb_v = -1; lb_h = -1; lb_v = -1;
        h79 = -1; v79 = -1; pe79 = -1; h80 = -1; v80 = -1;
        h799 = -1; v799 = -1; pe799 = -1; h800 = -1; v800 = -1;
        ft800 = -1; vs800 = -1; br800 = -1;
        n_gt1 = 0; n_hs_d = 0; n_br_d = 0; d_h = -1; d_v = -1;

        // Reset for 3 clk; every output must sit at zero.
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs_small", int'({if_s.pix_en, if_s.hCount, if_s.vCount, if_s.hSync,
                                       if_s.vSync, if_s.bright, if_s.frame_tick,
                                       if_s.game_tick}), 0);
        chk("rst_outputs_vga640", int'({if_d.pix_en, if_d.hCount, if_d.vCount, if_d.hSync,
                                        if_d.vSync, if_d.bright, if_d.frame_tick,
                                        if_d.game_tick}), 0);
        rst = 1'b0;

        // Free-run 13 small frames (and ~3 lines of the 640x480 raster).
        for (int c = 0; c < 13 * FR + 20; c++) begin
            @(negedge clk);
            if (if_s.pix_en && first_pe < 0) first_pe = k_m;
            if (k_m == 4) h_at4 = int'(if_s.hCount);
            if (k_m < FR && if_s.pix_en) begin
                n_pe++;
                if (if_s.bright) n_br++;
            end
            if (k_m < 80 && if_s.pix_en && !if_s.hSync) n_hs++;
            if (k_m < FR && if_s.bright) begin
                if (fb_h < 0) begin
                    fb_h = int'(if_s.hCount);
                    fb_v = int'(if_s.vCount);
                end
                lb_h = int'(if_s.hCount);
                lb_v = int'(if_s.vCount);
            end
            if (k_m == 79) begin
                h79 = int'(if_s.hCount); v79 = int'(if_s.vCount); pe79 = int'(if_s.pix_en);
            end
            if (k_m == 80) begin
                h80 = int'(if_s.hCount); v80 = int'(if_s.vCount);
            end
            if (k_m == 799) begin
                h799 = int'(if_s.hCount); v799 = int'(if_s.vCount); pe799 = int'(if_s.pix_en);
            end
            if (k_m == 800) begin
                h800 = int'(if_s.hCount); v800 = int'(if_s.vCount);
                ft800 = int'(if_s.frame_tick); vs800 = int'(if_s.vSync);
                br800 = int'(if_s.bright);
            end
            if (if_s.frame_tick) ft_q.push_back(k_m);
            if (if_s.game_tick) gt_q.push_back(k_m);
            if (if_1.game_tick) n_gt1++;
            if (k_m < 3200 && if_d.pix_en && !if_d.hSync) n_hs_d++;
            if (k_m < 3200 && if_d.bright) n_br_d++;
            if (k_m == 3200) begin
                d_h = int'(if_d.hCount); d_v = int'(if_d.vCount);
            end
        end

        chk("first_pix_en_k", first_pe, 3);
        chk("hcount_after_first_pix", h_at4, 1);
        chk("pix_en_per_frame", n_pe, 200);
        chk("hsync_low_strobes", n_hs, 3);
        chk("line_end_h", h79, 19);
        chk("line_end_v", v79, 0);
        chk("line_end_pix_en", pe79, 1);
        chk("line_wrap_h", h80, 0);
        chk("line_wrap_v", v80, 1);
        chk("bright_strobes", n_br, 72);
        chk("first_bright_h", fb_h, 5);
        chk("first_bright_v", fb_v, 3);
        chk("last_bright_h", lb_h, 16);
        chk("last_bright_v", lb_v, 8);
        chk("corner_h", h799, 19);
        chk("corner_v", v799, 9);
        chk("corner_pix_en", pe799, 1);
        chk("wrap_h", h800, 0);
        chk("wrap_v", v800, 0);
        chk("wrap_frame_tick", ft800, 1);
        chk("wrap_vsync", vs800, 0);
        chk("wrap_bright", br800, 0);
        chk("frame_tick_count", ft_q.size(), 13);
        for (int i = 0; i < ft_q.size(); i++)
            chk($sformatf("frame_tick_k[%0d]", i), ft_q[i], FR * (i + 1));
        chk("game_tick_count", gt_q.size(), 2);
        if (gt_q.size() == 2) begin
            chk("game_tick_k[0]", gt_q[0], 6 * FR);
            chk("game_tick_k[1]", gt_q[1], 12 * FR);
        end
        chk("tick1_game_ticks", n_gt1, 13);
        chk("vga640_hsync_low_strobes", n_hs_d, 96);
        chk("vga640_bright_line0", n_br_d, 0);
        chk("vga640_line_wrap_h", d_h, 0);
        chk("vga640_line_wrap_v", d_v, 1);

        // Mid-frame reset at small-raster position (10,6), held for one edge.
        found = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (if_s.hCount == 10'd10 && if_s.vCount == 10'd6) begin
                found = 1;
                break;
            end
        end
        chk("reach_mid_frame", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_h", int'(if_s.hCount), 0);
        chk("midrst_v", int'(if_s.vCount), 0);
        chk("midrst_hsync", int'(if_s.hSync), 0);
        chk("midrst_bright", int'(if_s.bright), 0);
        chk("midrst_frame_tick", int'(if_s.frame_tick), 0);
        rst = 1'b0;
        ft_k = -1;
        gt_k = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (if_s.game_tick && gt_k < 0) gt_k = k_m;
            if (if_s.frame_tick) begin
                ft_k = k_m;
                break;
            end
        end
        chk("midrst_next_frame_tick", ft_k, FR);
        chk("midrst_no_game_tick", gt_k, -1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
